// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable pattern and overlap mode,
// a one-cycle registered match pulse, and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned        PAT_LEN     = 4,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(4'b1001),
  parameter logic               RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic               accept;
  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  // Sample acceptance and match detection on the post-shift history.
  always_comb begin
    accept     = x_valid & ~cfg_load;
    hist_shift = {hist_q[PAT_LEN-2:0], x};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    hit        = accept && (fill_inc == FILL_FULL) && (hist_shift == pattern_q);
  end

  // Config, history and fill next state; a load flushes history and wins over a sample.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      // Non-overlapping mode restarts the fill so the next occurrence needs fresh bits.
      fill_d = (hit && !overlap_q) ? '0 : fill_inc;
    end
  end

  // Match pulse and saturating counter; clear beats a coincident increment.
  always_comb begin
    match_d = hit;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (count_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PATTERN;
      overlap_q <= RST_OVERLAP;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a default instance and a 2-bit-counter instance
// share stimulus; both are checked against a queue-based reference model.
module tb_seq_detector_param;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         x_valid, x, cfg_load, cfg_overlap, count_clr;
  logic [P-1:0] cfg_pattern;
  logic         match_a, sat_a;
  logic [15:0]  cnt_a;
  logic         match_b, sat_b;
  logic [1:0]   cnt_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit           hq[$];
  logic [P-1:0] m_pat;
  bit           m_ov;
  bit           e_match;
  int           n_a, n_b;
  bit           s_a, s_b;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .match(match_a), .match_count(cnt_a), .count_sat(sat_a));

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .match(match_b), .match_count(cnt_b), .count_sat(sat_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".match_a"}, 32'(match_a), 32'(e_match));
    chk({tag, ".cnt_a"},   32'(cnt_a),   32'(n_a));
    chk({tag, ".sat_a"},   32'(sat_a),   32'(s_a));
    chk({tag, ".match_b"}, 32'(match_b), 32'(e_match));
    chk({tag, ".cnt_b"},   32'(cnt_b),   32'(n_b));
    chk({tag, ".sat_b"},   32'(sat_b),   32'(s_b));
  endtask

  function automatic void model_reset();
    hq.delete();
    m_pat = 4'b1001; m_ov = 1'b1; e_match = 1'b0;
    n_a = 0; n_b = 0; s_a = 1'b0; s_b = 1'b0;
  endfunction

  // Model of one clock edge: keep the last P accepted bits since the last flush,
  // compare them against the pattern (oldest bit = pattern MSB).
  function automatic void model_edge(input bit v, input bit b, input bit ld,
                                     input logic [P-1:0] p, input bit ov, input bit clr);
    bit eq;
    e_match = 1'b0;
    if (ld) begin
      m_pat = p; m_ov = ov; hq.delete();
    end else if (v) begin
      hq.push_back(b);
      if (hq.size() > P) void'(hq.pop_front());
      if (hq.size() == P) begin
        eq = 1'b1;
        for (int i = 0; i < P; i++) if (hq[i] != m_pat[P-1-i]) eq = 1'b0;
        e_match = eq;
      end
      if (e_match && !m_ov) hq.delete();
    end
    if (clr) begin
      n_a = 0; n_b = 0; s_a = 1'b0; s_b = 1'b0;
    end else if (e_match) begin
      n_a = (n_a < 65535) ? n_a + 1 : 65535;
      n_b = (n_b < 3) ? n_b + 1 : 3;
    end
    if (n_a == 65535) s_a = 1'b1;
    if (n_b == 3)     s_b = 1'b1;
  endfunction

  task automatic step(input string tag, input bit v, input bit b, input bit ld = 1'b0,
                      input logic [P-1:0] p = 4'b0000, input bit ov = 1'b0,
                      input bit clr = 1'b0);
    x_valid = v; x = b; cfg_load = ld; cfg_pattern = p; cfg_overlap = ov; count_clr = clr;
    @(posedge clk);
    model_edge(v, b, ld, p, ov, clr);
    #1;
    check_all(tag);
  endtask

  task automatic bits(input string tag, input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, seq[i]);
  endtask

  initial begin
    reset = 1'b1; x_valid = 1'b0; x = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #9 reset = 1'b0;

    // Defaults (1001, overlapping): 1001001 -> matches after samples 4 and 7
    bits("ovl", 16'b1001001, 7);
    chk("ovl.count2", 32'(cnt_a), 32'd2);

    // Non-overlapping 1001, same stream -> one more match only
    step("ld_nov", 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0);
    bits("nov", 16'b1001001, 7);
    chk("nov.count3", 32'(cnt_a), 32'd3);

    // Pattern 0001: lone 1 after load cannot match; then 0001 matches once
    step("ld_0001", 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1);
    step("fill1", 1'b1, 1'b1);
    bits("0001", 16'b0001, 4);
    // Load with a coincident sample: sample dropped, so 001 is not enough
    step("ld_v", 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1);
    bits("ld_v_tail", 16'b001, 3);
    step("ld_v_done", 1'b1, 1'b1);

    // Defaults back; gaps hold history and keep match low
    step("ld_def", 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1);
    step("gap_s1", 1'b1, 1'b1);
    step("gap1", 1'b0, 1'b0);
    step("gap_s2", 1'b1, 1'b0);
    step("gap2a", 1'b0, 1'b1);
    step("gap2b", 1'b0, 1'b1);
    step("gap_s3", 1'b1, 1'b0);
    step("gap_s4", 1'b1, 1'b1);
    step("gap_after", 1'b0, 1'b0);

    // Saturation of the 2-bit counter, clear, then clear coincident with a match
    step("clr0", 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    bits("sat", 16'b1001001001001, 13);
    chk("sat.cnt_b3", 32'(cnt_b), 32'd3);
    chk("sat.sat_b1", 32'(sat_b), 32'd1);
    step("clr1", 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    bits("pre_co", 16'b001, 3);
    step("clr_co", 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);

    // Reset pulse mid-cycle after a partial sequence
    bits("pre_rst", 16'b100, 3);
    #1 reset = 1'b1;
    model_reset();
    #1 check_all("in_rst");
    #1 reset = 1'b0;
    step("post_rst", 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(99) < 80), 1'($urandom), ($urandom_range(99) < 4),
           4'($urandom), 1'($urandom), ($urandom_range(99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
